compute_watchdog: RTL and testbench
===================================

# compute_watchdog

Supervises one matrix-computation operation at a time and drives the countdown timer stage that sits directly downstream of it. On an accepted request it launches the compute engine and the countdown timer together. It then waits for either the engine's completion or the timer's timeout. Finally it reports the outcome and pulses `abort` on expiry so the top level can reset the engine and flag the error.

## Interface
- `DUR_W`, 16: width of duration values; matches the countdown timer `duration` input.
- `DEFAULT_DURATION`, 16'd10: duration used when a request supplies 0.
- `ERR_W`, 8: width of the timeout error counter.

Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `op_req`  in  1  request to start an operation (level; held until `op_ack`)
- `op_duration`  in  DUR_W  timeout for this request; sampled with `op_req`
- `op_ack`  out  1  one-cycle accept pulse
- `op_start`  out  1  one-cycle start pulse to compute engine
- `op_done`  in  1  completion pulse from compute engine
- `tmr_start`  out  1  one-cycle start pulse to countdown timer
- `tmr_duration`  out  DUR_W  registered duration to countdown timer; stable from `tmr_start` until next accept
- `tmr_timeout`  in  1  countdown timer expiry (level)
- `abort`  out  1  one-cycle pulse on final timeout
- `busy`  out  1  high from accept until outcome is recorded
- `status`  out  2  last outcome: 00 none, 01 done OK, 10 timed out
- `err_cnt`  out  ERR_W  saturating count of final timeouts

## Operation
- States: IDLE, ARM, RUN, FINISH.
- **IDLE**
  - `op_req` high → latch `op_duration` into `tmr_duration`; if it is 0, latch `DEFAULT_DURATION` instead.
  - Go to ARM.
- **ARM** (one cycle)
  - `op_ack`, `op_start` and `tmr_start` are all high.
  - Clear the `armed` flag; go to RUN.
- **RUN**
  - Set `armed` on the first cycle `tmr_timeout` is sampled low. This is the stale-level guard: a timeout level left over from a previous countdown is ignored.
  - `op_done` → status 01, go to FINISH.
  - `tmr_timeout` high with `armed` set → final timeout:
    - `abort` pulses;
    - status 10;
    - `err_cnt` += 1, saturating at all-ones;
    - go to FINISH.
  - `op_done` and a valid timeout in the same cycle → done wins; no abort.
- **FINISH** (one cycle)
  - `busy` drops; go to IDLE.
  - `op_req` is not accepted in this cycle.
- `op_done` outside RUN is ignored. `tmr_timeout` outside RUN is ignored.
- `op_req` while busy is not acknowledged and stays pending.
- After a successful done, the downstream timer keeps running; its later expiry is ignored. The next `tmr_start` restarts it.
- Reset values: `op_ack`=0, `op_start`=0, `tmr_start`=0, `abort`=0, `busy`=0, `tmr_duration`=0, `status`=00, `err_cnt`=0, state IDLE, `armed`=0.
- Reset mid-RUN: return to IDLE without pulsing `abort`.

## Timing
- `op_req` sampled high in IDLE at cycle N → ARM at N+1, with `op_ack`/`op_start`/`tmr_start` high in cycle N+1 only.
- `busy` is high from N+1. RUN starts at N+2.
- `op_done` sampled at cycle M in RUN → `status` updated at M+1 (FINISH); `busy` low at M+2.
- Valid timeout sampled at cycle M → `abort` high at M+1 only; `status` and `err_cnt` update at M+1; `busy` low at M+2.
- Minimum request-to-request spacing is 4 cycles.
- All outputs are registered.

## Configuration
- Macro: `WDG_RETRY_EN`.
- **Defined:** the first timeout of an operation does not abort.
  - Instead, `op_start` and `tmr_start` re-pulse one cycle later, with the same `tmr_duration`.
  - `armed` clears and the block stays busy in RUN.
  - Only a second timeout is final: `abort`, status 10, `err_cnt` += 1.
  - `op_done` after a retry gives status 01.
- **Undefined:** the first valid timeout is final; no retry logic is present.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, `status`=00, `err_cnt`=0.
- `op_req` with `op_duration`=16'd5, then `op_done` 20 cycles later → single-cycle `op_ack`/`op_start`/`tmr_start` together, `tmr_duration`=5, `status`=01, no `abort`, `err_cnt`=0.
- `op_duration`=0, timer toggles low, then raises `tmr_timeout` → `tmr_duration`=10, exactly one `abort` pulse, `status`=10, `err_cnt`=1 (with `WDG_RETRY_EN`: one retry restart, `abort` after second expiry).
- `tmr_timeout` held high from before the request through 3 RUN cycles, then `op_done` → no abort, `status`=01.
- `op_done` and armed `tmr_timeout` in the same cycle → `status`=01, no `abort`; `op_req` held during busy → acked only after return to IDLE.
- 256 forced timeouts with ERR_W=8 → `err_cnt` saturates at 255; `rst` asserted mid-RUN → IDLE next cycle, no `abort`, `err_cnt`=0.

Source files
------------

// File: rtl/compute_watchdog.sv
// -----------------------------------------------------------------------------
// compute_watchdog
//
// Supervises one matrix-computation operation at a time. An accepted request
// launches the compute engine and the downstream countdown timer together.
// The block then waits for the engine's completion or the timer's expiry. It
// reports the outcome in `status`, and on a final expiry it pulses `abort` and
// bumps a saturating error counter.
//
// Optional feature (compile-time macro WDG_RETRY_EN):
//   defined   - the first valid timeout of an operation restarts the engine and
//               the timer once, and only a second timeout is final.
//   undefined - the first valid timeout is final.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   op_req        in   start request (level, held until op_ack)
//   op_duration   in   timeout for this request, sampled with op_req (0 = default)
//   op_ack        out  one-cycle accept pulse
//   op_start      out  one-cycle start pulse to the compute engine
//   op_done       in   completion pulse from the compute engine
//   tmr_start     out  one-cycle start pulse to the countdown timer
//   tmr_duration  out  registered duration for the countdown timer
//   tmr_timeout   in   countdown timer expiry level
//   abort         out  one-cycle pulse on a final timeout
//   busy          out  high from accept until the outcome has been recorded
//   status        out  last outcome: 00 none, 01 done OK, 10 timed out
//   err_cnt       out  saturating count of final timeouts
// -----------------------------------------------------------------------------
module compute_watchdog #(
    parameter int unsigned        DUR_W            = 16,
    parameter logic [DUR_W-1:0]   DEFAULT_DURATION = DUR_W'(10),
    parameter int unsigned        ERR_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_req,
    input  logic [DUR_W-1:0] op_duration,
    output logic             op_ack,
    output logic             op_start,
    input  logic             op_done,
    output logic             tmr_start,
    output logic [DUR_W-1:0] tmr_duration,
    input  logic             tmr_timeout,
    output logic             abort,
    output logic             busy,
    output logic [1:0]       status,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0]       STATUS_NONE    = 2'b00;
    localparam logic [1:0]       STATUS_OK      = 2'b01;
    localparam logic [1:0]       STATUS_TIMEOUT = 2'b10;
    localparam logic [ERR_W-1:0] ERR_MAX        = '1;

    state_t state;

    // Stale-level guard: a timeout only counts once the timer has been seen
    // low after its most recent start, so a level left high by an earlier
    // countdown cannot end the new operation.
    logic armed;

    logic valid_timeout;
    logic final_timeout;

    assign valid_timeout = tmr_timeout && armed;

`ifdef WDG_RETRY_EN
    // Set once the single restart of the current operation has been used.
    logic retried;
    logic retry_now;

    // Completion in the same cycle always wins over any timeout.
    assign retry_now     = valid_timeout && !op_done && !retried;
    assign final_timeout = valid_timeout && !op_done &&  retried;
`else
    // Completion in the same cycle always wins over any timeout.
    assign final_timeout = valid_timeout && !op_done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            op_ack       <= 1'b0;
            op_start     <= 1'b0;
            tmr_start    <= 1'b0;
            abort        <= 1'b0;
            busy         <= 1'b0;
            tmr_duration <= '0;
            status       <= STATUS_NONE;
            err_cnt      <= '0;
`ifdef WDG_RETRY_EN
            retried      <= 1'b0;
`endif
        end else begin
            // NOTE: every pulse output is driven low first and raised below only
            // in the cycle it must appear; with non-blocking assignments the
            // last assignment in this block wins, so no output can stick high.
            op_ack    <= 1'b0;
            op_start  <= 1'b0;
            tmr_start <= 1'b0;
            abort     <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (op_req) begin
                        tmr_duration <= (op_duration == '0) ? DEFAULT_DURATION
                                                            : op_duration;
                        op_ack       <= 1'b1;
                        op_start     <= 1'b1;
                        tmr_start    <= 1'b1;
                        busy         <= 1'b1;
`ifdef WDG_RETRY_EN
                        retried      <= 1'b0;
`endif
                        state        <= ARM;
                    end
                end

                ARM: begin
                    armed <= 1'b0;
                    state <= RUN;
                end

                RUN: begin
                    if (!tmr_timeout) begin
                        armed <= 1'b1;
                    end

                    if (op_done) begin
                        status <= STATUS_OK;
                        state  <= FINISH;
                    end else if (final_timeout) begin
                        abort  <= 1'b1;
                        status <= STATUS_TIMEOUT;
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        state  <= FINISH;
                    end
`ifdef WDG_RETRY_EN
                    else if (retry_now) begin
                        // Restart engine and timer with the same duration;
                        // the timer must be seen low again before the next
                        // timeout counts.
                        op_start  <= 1'b1;
                        tmr_start <= 1'b1;
                        armed     <= 1'b0;
                        retried   <= 1'b1;
                    end
`endif
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compute_watchdog.sv
// -----------------------------------------------------------------------------
// tb_compute_watchdog
//
// Self-checking bench for compute_watchdog. An operation-level reference model
// (acceptance, cycles since acceptance, watch guard, remaining retries, closing
// flag) predicts every output on every cycle. Directed scenarios with
// hand-computed expectations pin the model, and a randomized phase follows.
// Honours WDG_RETRY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_compute_watchdog;

    localparam int DUR_W   = 16;
    localparam int ERR_W   = 8;
    localparam int DEF_DUR = 10;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef WDG_RETRY_EN
    localparam int RETRIES = 1;
`else
    localparam int RETRIES = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             op_req = 1'b0;
    logic [DUR_W-1:0] op_duration = '0;
    logic             op_done = 1'b0;
    logic             tmr_timeout = 1'b0;
    logic             op_ack;
    logic             op_start;
    logic             tmr_start;
    logic [DUR_W-1:0] tmr_duration;
    logic             abort;
    logic             busy;
    logic [1:0]       status;
    logic [ERR_W-1:0] err_cnt;

    compute_watchdog #(
        .DUR_W            (DUR_W),
        .DEFAULT_DURATION (16'd10),
        .ERR_W            (ERR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_req       (op_req),
        .op_duration  (op_duration),
        .op_ack       (op_ack),
        .op_start     (op_start),
        .op_done      (op_done),
        .tmr_start    (tmr_start),
        .tmr_duration (tmr_duration),
        .tmr_timeout  (tmr_timeout),
        .abort        (abort),
        .busy         (busy),
        .status       (status),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // An operation is "in flight" from acceptance until one cycle after its
    // outcome. Age counts clock edges since acceptance: edge 1 is the launch
    // cycle ending, and from edge 2 on the engine and timer inputs are watched.
    bit m_valid = 1'b0;
    bit e_busy, e_closing, m_guard, valid_to;
    bit e_ack, e_start, e_tstart, e_abort;
    int m_age, m_tries, e_status, e_err, e_dur;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            e_busy = 0; e_closing = 0; m_guard = 0;
            e_ack = 0; e_start = 0; e_tstart = 0; e_abort = 0;
            m_age = 0; m_tries = 0; e_status = 0; e_err = 0; e_dur = 0;
        end else if (m_valid) begin
            e_ack = 0; e_start = 0; e_tstart = 0; e_abort = 0;
            if (!e_busy) begin
                if (op_req) begin
                    e_busy    = 1;
                    e_closing = 0;
                    m_age     = 0;
                    m_tries   = RETRIES;
                    m_guard   = 0;
                    e_dur     = (op_duration == 0) ? DEF_DUR : int'(op_duration);
                    e_ack = 1; e_start = 1; e_tstart = 1;
                end
            end else if (e_closing) begin
                e_busy    = 0;
                e_closing = 0;
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_guard = 0;
                end else begin
                    valid_to = tmr_timeout && m_guard;
                    if (!tmr_timeout) m_guard = 1;
                    if (op_done) begin
                        e_status  = 1;
                        e_closing = 1;
                    end else if (valid_to) begin
                        if (m_tries > 0) begin
                            m_tries--;
                            e_start = 1; e_tstart = 1;
                            m_guard = 0;
                        end else begin
                            e_abort   = 1;
                            e_status  = 2;
                            e_err     = (e_err < ERR_MAX) ? e_err + 1 : ERR_MAX;
                            e_closing = 1;
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle once the first reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            check("op_ack",       op_ack,       e_ack);
            check("op_start",     op_start,     e_start);
            check("tmr_start",    tmr_start,    e_tstart);
            check("abort",        abort,        e_abort);
            check("busy",         busy,         e_busy);
            check("status",       status,       e_status);
            check("err_cnt",      err_cnt,      e_err);
            check("tmr_duration", tmr_duration, e_dur);
        end
    end

    // Pulse counters used by the directed scenarios.
    int abort_seen = 0, tstart_seen = 0, ack_seen = 0;
    always @(negedge clk) begin
        if (abort === 1'b1)     abort_seen++;
        if (tmr_start === 1'b1) tstart_seen++;
        if (op_ack === 1'b1)    ack_seen++;
    end

    // Inputs change 1 time unit after the falling edge, well clear of posedge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic force_timeout();
        op_req = 1; op_duration = 16'd1;
        tick();
        op_req = 0; tmr_timeout = 0;
        tick(2);
        for (int r = 0; r <= RETRIES; r++) begin
            tmr_timeout = 1;
            tick();
            tmr_timeout = 0;
            tick(2);
        end
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no finish, expected finish before %0t", $time);
        $fatal(1, "time limit reached");
    end

    int a0, s0, k0;

    initial begin
        // ---- reset, then idle ----
        rst = 1; tick(2); rst = 0; tick(5);
        check("rst_op_ack", op_ack, 0);
        check("rst_op_start", op_start, 0);
        check("rst_tmr_start", tmr_start, 0);
        check("rst_abort", abort, 0);
        check("rst_busy", busy, 0);
        check("rst_tmr_duration", tmr_duration, 0);
        check("rst_status", status, 0);
        check("rst_err_cnt", err_cnt, 0);

        // ---- normal completion, duration 5 ----
        a0 = abort_seen;
        op_req = 1; op_duration = 16'd5;
        tick();
        check("ok_ack", op_ack, 1);
        check("ok_start", op_start, 1);
        check("ok_tmr_start", tmr_start, 1);
        check("ok_tmr_duration", tmr_duration, 5);
        check("ok_busy", busy, 1);
        op_req = 0; op_duration = 16'($urandom_range(1, 999));
        tick();
        check("ok_ack_single", op_ack, 0);
        check("ok_tmr_start_single", tmr_start, 0);
        tick(18);
        op_done = 1; tick(); op_done = 0;
        check("ok_status", status, 1);
        check("ok_busy_finish", busy, 1);
        tick();
        check("ok_busy_drop", busy, 0);
        check("ok_no_abort", abort_seen - a0, 0);
        check("ok_err_cnt", err_cnt, 0);
        check("ok_duration_held", tmr_duration, 5);

        // ---- zero duration -> default, then timeout ----
        a0 = abort_seen; s0 = tstart_seen;
        op_req = 1; op_duration = 16'd0;
        tick();
        check("to_default_duration", tmr_duration, DEF_DUR);
        op_req = 0;
        tick(3);
        tmr_timeout = 1; tick(); tmr_timeout = 0;
        tick(3);
        tmr_timeout = 1; tick(); tmr_timeout = 0;
        tick(4);
        check("to_abort_count", abort_seen - a0, 1);
        check("to_tmr_start_count", tstart_seen - s0, 1 + RETRIES);
        check("to_status", status, 2);
        check("to_err_cnt", err_cnt, 1);
        check("to_busy", busy, 0);

        // ---- stale timeout level ignored ----
        a0 = abort_seen;
        tmr_timeout = 1; op_req = 1; op_duration = 16'd7;
        tick(); op_req = 0;
        tick();
        tick(3);
        op_done = 1; tick(); op_done = 0; tmr_timeout = 0;
        check("stale_status", status, 1);
        check("stale_no_abort", abort_seen - a0, 0);
        tick(2);
        check("stale_busy", busy, 0);

        // ---- done and armed timeout together; held request ----
        a0 = abort_seen; k0 = ack_seen;
        op_req = 1; op_duration = 16'd3;
        tick();
        tick(3);
        op_done = 1; tmr_timeout = 1;
        tick();
        op_done = 0; tmr_timeout = 0;
        check("tie_status", status, 1);
        check("tie_no_abort", abort_seen - a0, 0);
        check("held_req_single_ack", ack_seen - k0, 1);
        tick();
        check("held_req_busy_low", busy, 0);
        check("held_req_no_ack_finish", op_ack, 0);
        tick();
        check("held_req_acked", op_ack, 1);
        op_req = 0;
        tick(3);
        op_done = 1; tick(); op_done = 0;
        tick(2);

        // ---- error counter saturation ----
        rst = 1; tick(); rst = 0; tick();
        for (int i = 0; i < 256; i++) begin
            force_timeout();
            if (i == 254) check("sat_err_255", err_cnt, 255);
        end
        check("sat_err_256", err_cnt, 255);
        check("sat_status", status, 2);

        // ---- reset mid-RUN ----
        op_req = 1; op_duration = 16'd20;
        tick(); op_req = 0;
        tick(3);
        check("midrst_busy_before", busy, 1);
        a0 = abort_seen;
        rst = 1; tmr_timeout = 1;
        tick();
        rst = 0;
        check("midrst_busy", busy, 0);
        check("midrst_abort", abort, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_status", status, 0);
        tick(2);
        tmr_timeout = 0;
        check("midrst_no_abort", abort_seen - a0, 0);
        check("midrst_idle", busy, 0);

        // ---- randomized traffic ----
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) op_req = ~op_req;
            op_duration = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 50));
            op_done = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 4) == 0) tmr_timeout = ~tmr_timeout;
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 0; op_req = 0; op_done = 0; tmr_timeout = 0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
